uart_tx_async_rst: RTL



---
 rtl/uart_tx_async_rst_if.sv | 26 ++
 rtl/uart_tx_async_rst.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_async_rst_if.sv
// Parallel-side handshake and serial outputs of the UART transmitter.
interface uart_tx_async_rst_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 TX_OUT;
    logic                 BUSY;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY,
        input  TX_OUT,
        input  BUSY
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/uart_tx_async_rst.sv
// UART transmitter: start bit, DATA_BITS LSB-first, STOP_BITS stop bits, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_async_rst #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_async_rst_if.slave tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_out_q, tx_out_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign tx.TX_OUT   = tx_out_q;
    assign tx.TX_READY = ready_q;
    assign tx.BUSY     = busy_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so that TX_OUT/TX_READY/BUSY come straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_out_d = tx_out_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx.TX_VALID) begin
                    state_d  = START;
                    shift_d  = tx.TX_DATA;
                    tx_out_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx.TX_DATA;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_out_d = parity_q;
`else
                        state_d  = STOP;
                        tx_out_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        tx_out_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    idx_d    = '0;
                    tx_out_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        tx_out_d = 1'b1;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                tx_out_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

endmodule
